fetch_unit: RTL

- Instruction-fetch stage of the five-stage MIPS pipeline.
- Owns the program counter, the instruction-memory read request, next-PC selection (sequential / branch / jump), and the IF/ID pipeline latch.
- Sits directly upstream of decode and is driven by the hazard unit's pcWEN, IFID_enable and IFID_flush outputs.
- Its iREN/ihit handshake with the instruction cache produces the ihit the hazard unit consumes.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : MIPS instruction-fetch stage. It holds the PC, drives the
//             I-cache read request, selects the next PC (sequential, branch
//             or jump) and owns the IF/ID pipeline latch.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pcWEN,
  input  logic        IFID_enable,
  input  logic        IFID_flush,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_npc,
  output logic        IFID_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_pend_v;
  logic        w_pend_v_nxt;
  logic [31:0] r_pend_addr;
  logic [31:0] w_pend_addr_nxt;
  logic [31:0] w_pc_plus4;

  // Sequential successor; wraps naturally modulo 2^32.
  assign w_pc_plus4 = r_pc + 32'd4;

  assign iaddr  = r_pc;
  assign iREN   = (r_state != HALTED);
  assign halted = (r_state == HALTED);

  // State, PC and pending-redirect registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_pc        <= PC_INIT;
      r_pend_v    <= 1'b0;
      r_pend_addr <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  // Next-state / next-PC: halt beats everything, then a PC write consumes
  // redirects, otherwise a redirect is parked until the PC may move.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_v_nxt    = r_pend_v;
    w_pend_addr_nxt = r_pend_addr;

    if (halt) begin
      w_state_nxt  = HALTED;
      w_pend_v_nxt = 1'b0;
    end else if (r_state == HALTED) begin
      w_state_nxt  = HALTED;
      w_pend_v_nxt = 1'b0;
    end else if (pcWEN) begin
      if (branch_taken)    w_pc_nxt = branch_target;
      else if (r_pend_v)   w_pc_nxt = r_pend_addr;
      else if (jump_taken) w_pc_nxt = jump_target;
      else                 w_pc_nxt = w_pc_plus4;
      w_pend_v_nxt = 1'b0;
      w_state_nxt  = RUN;
    end else if (branch_taken) begin
      // A later branch supersedes whatever was parked.
      w_pend_addr_nxt = branch_target;
      w_pend_v_nxt    = 1'b1;
      w_state_nxt     = PEND;
    end else if (jump_taken) begin
      // An already parked redirect is older and therefore wins over a jump.
      if (!r_pend_v) w_pend_addr_nxt = jump_target;
      w_pend_v_nxt = 1'b1;
      w_state_nxt  = PEND;
    end
  end

  // IF/ID latch: flush first, then load (real fetch or halted bubble), else hold.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      IFID_instr <= NOP_WORD;
      IFID_pc    <= 32'h0;
      IFID_npc   <= 32'h0;
      IFID_valid <= 1'b0;
    end else if (IFID_flush) begin
      IFID_instr <= NOP_WORD;
      IFID_pc    <= 32'h0;
      IFID_npc   <= 32'h0;
      IFID_valid <= 1'b0;
    end else if (IFID_enable && (r_state != HALTED)) begin
      IFID_instr <= ihit ? iload : NOP_WORD;
      IFID_pc    <= r_pc;
      IFID_npc   <= w_pc_plus4;
      IFID_valid <= ihit;
    end else if (IFID_enable) begin
      IFID_instr <= NOP_WORD;
      IFID_pc    <= 32'h0;
      IFID_npc   <= 32'h0;
      IFID_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
